// File: rtl/ceyloniac_alu_operand_sel_pipe.sv
// Registered ALU B-operand select stage: N-way source select, immediate extend modes,
// one-deep output register backed by a one-entry skid buffer on a valid/ready handshake.
module ceyloniac_alu_operand_sel_pipe #(
  parameter int unsigned ALU_DATA_WIDTH = 32,
  parameter int unsigned NUM_INPUTS     = 8,
  parameter int unsigned SEL_WIDTH      = 3,
  parameter int unsigned IMM_WIDTH      = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [SEL_WIDTH-1:0]                 alu_src_sel,
  input  logic [1:0]                           ext_mode,
  input  logic [NUM_INPUTS*ALU_DATA_WIDTH-1:0] mux_in,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [ALU_DATA_WIDTH-1:0]            out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 sel_err,
  input  logic                                 err_clr
);

  localparam int unsigned ExtWidth = ALU_DATA_WIDTH - IMM_WIDTH;

  typedef enum logic [1:0] {
    ExtPass     = 2'b00,
    ExtSign     = 2'b01,
    ExtZero     = 2'b10,
    ExtSignShl2 = 2'b11
  } ext_mode_e;

  logic [ALU_DATA_WIDTH-1:0] raw;
  logic [IMM_WIDTH-1:0]      imm;
  logic [ALU_DATA_WIDTH-1:0] imm_sext;
  logic [ALU_DATA_WIDTH-1:0] imm_zext;
  logic [ALU_DATA_WIDTH-1:0] result;
  logic                      sel_bad;

  logic                      out_valid_q, out_valid_d;
  logic [ALU_DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                      skid_valid_q, skid_valid_d;
  logic [ALU_DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                      sel_err_q, sel_err_d;

  logic                      accept;
  logic                      out_free;

  // Out-of-range selects read as zero rather than aliasing onto a real source.
  always_comb begin
    raw = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      if (32'(alu_src_sel) == k) begin
        raw = mux_in[k*ALU_DATA_WIDTH +: ALU_DATA_WIDTH];
      end
    end
  end

  assign sel_bad  = 32'(alu_src_sel) >= NUM_INPUTS;
  assign imm      = raw[IMM_WIDTH-1:0];
  assign imm_sext = {{ExtWidth{imm[IMM_WIDTH-1]}}, imm};
  assign imm_zext = {{ExtWidth{1'b0}}, imm};

  always_comb begin
    result = raw;
    case (ext_mode_e'(ext_mode))
      ExtPass:     result = raw;
      ExtSign:     result = imm_sext;
      ExtZero:     result = imm_zext;
      ExtSignShl2: result = imm_sext << 2;
      default:     result = raw;
    endcase
  end

  assign in_ready = !reset && !skid_valid_q;
  assign accept   = in_valid && in_ready;
  // Output register can take new content when it is empty or being drained this edge.
  assign out_free = !out_valid_q || out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (out_free) begin
      if (skid_valid_q) begin
        // in_ready is low whenever skid is occupied, so nothing new arrives here.
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = result;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = result;
    end
  end

  // A set event in the same cycle as a clear takes precedence.
  always_comb begin
    sel_err_d = sel_err_q;
    if (accept && sel_bad) begin
      sel_err_d = 1'b1;
    end else if (err_clr) begin
      sel_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      sel_err_q    <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      sel_err_q    <= sel_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_ceyloniac_alu_operand_sel_pipe.sv
// Bench for ceyloniac_alu_operand_sel_pipe: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the stage.
module tb_ceyloniac_alu_operand_sel_pipe;

  localparam int unsigned W    = 32;
  localparam int unsigned NIN  = 6;
  localparam int unsigned SELW = 3;
  localparam int unsigned IMMW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [SELW-1:0]   alu_src_sel;
  logic [1:0]        ext_mode;
  logic [NIN*W-1:0]  mux_in;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      out_data;
  logic              out_valid;
  logic              out_ready;
  logic              sel_err;
  logic              err_clr;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  logic [W-1:0] mq[$];
  bit           m_err = 1'b0;
  bit           m_acc;
  bit           rst_seen = 1'b0;
  logic [W-1:0] srcv[8];

  ceyloniac_alu_operand_sel_pipe #(
    .ALU_DATA_WIDTH(W),
    .NUM_INPUTS    (NIN),
    .SEL_WIDTH     (SELW),
    .IMM_WIDTH     (IMMW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_src_sel(alu_src_sel),
    .ext_mode   (ext_mode),
    .mux_in     (mux_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sel_err    (sel_err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_result(input int sel, input int mode,
                                                input logic [NIN*W-1:0] srcs);
    logic [W-1:0] raw;
    logic [W-1:0] imm;
    logic [W-1:0] se;
    raw = (sel < int'(NIN)) ? srcs[sel*W +: W] : '0;
    imm = raw % 32'h1_0000;
    se  = (imm >= 32'h8000) ? imm - 32'h1_0000 : imm;
    case (mode)
      0:       return raw;
      1:       return se;
      2:       return imm;
      default: return se * 4;
    endcase
  endfunction

  // Model: the stage is an in-order FIFO of capacity two whose head is out_data.
  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      m_acc = in_valid && (mq.size() < 2);
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (m_acc) mq.push_back(model_result(int'(alu_src_sel), int'(ext_mode), mux_in));
      if (m_acc && int'(alu_src_sel) >= int'(NIN)) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
    rst_seen = reset;
  end

  always @(negedge clk) begin
    if (started) begin
      check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) check("out_data", out_data, mq[0]);
      check("in_ready", 32'(in_ready), 32'(!reset && mq.size() < 2));
      check("sel_err", 32'(sel_err), 32'(m_err));
      if (rst_seen) check("reset_out_data", out_data, '0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b1;
    alu_src_sel = 3'd5;
    ext_mode    = 2'b00;
    mux_in      = '0;
    mux_in[5*W +: W] = 32'hDEADBEEF;
    out_ready   = 1'b1;
    err_clr     = 1'b0;
    started     = 1'b1;

    // Reset held with a pending request.
    repeat (3) begin
      step();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'd0);
    end
    reset = 1'b0;
    step();
    check("pass_valid", 32'(out_valid), 32'd1);
    check("pass_data", out_data, 32'hDEADBEEF);

    // Back-to-back selects 0..7; 6 and 7 are out of range and must read zero.
    for (int k = 0; k < int'(NIN); k++) begin
      srcv[k] = $urandom();
      mux_in[k*W +: W] = srcv[k];
    end
    srcv[6] = '0;
    srcv[7] = '0;
    for (int i = 0; i < 8; i++) begin
      alu_src_sel = SELW'(i);
      step();
      check("b2b_data", out_data, srcv[i]);
    end
    in_valid = 1'b0;
    err_clr  = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_after_b2b", 32'(sel_err), 32'd0);

    // Extend modes on 0x00008004.
    mux_in[2*W +: W] = 32'h0000_8004;
    alu_src_sel = 3'd2;
    in_valid    = 1'b1;
    ext_mode    = 2'b01;
    step();
    check("ext_sign", out_data, 32'hFFFF8004);
    ext_mode = 2'b10;
    step();
    check("ext_zero", out_data, 32'h00008004);
    ext_mode = 2'b11;
    step();
    check("ext_shl2", out_data, 32'hFFFE0010);
    ext_mode = 2'b00;
    in_valid = 1'b0;
    step();

    // Backpressure: A, B, C with the consumer stalled.
    mux_in[0*W +: W] = 32'hAAAA_0001;
    mux_in[1*W +: W] = 32'hBBBB_0002;
    mux_in[3*W +: W] = 32'hCCCC_0003;
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    alu_src_sel = 3'd0;
    step();
    check("bp_a_out", out_data, 32'hAAAA_0001);
    check("bp_a_rdy", 32'(in_ready), 32'd1);
    alu_src_sel = 3'd1;
    step();
    check("bp_b_hold", out_data, 32'hAAAA_0001);
    check("bp_b_rdy", 32'(in_ready), 32'd0);
    alu_src_sel = 3'd3;
    step();
    check("bp_c_hold", out_data, 32'hAAAA_0001);
    check("bp_c_rdy", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    check("bp_drain_b", out_data, 32'hBBBB_0002);
    step();
    check("bp_drain_c", out_data, 32'hCCCC_0003);
    in_valid = 1'b0;
    step();
    check("bp_empty", 32'(out_valid), 32'd0);

    // Bad select: set, set-beats-clear, then clear.
    alu_src_sel = 3'd7;
    in_valid    = 1'b1;
    step();
    check("bad_data", out_data, 32'd0);
    check("bad_err", 32'(sel_err), 32'd1);
    err_clr = 1'b1;
    step();
    check("bad_set_wins", 32'(sel_err), 32'd1);
    in_valid = 1'b0;
    step();
    check("bad_cleared", 32'(sel_err), 32'd0);
    err_clr = 1'b0;

    // Reset with output and skid both full.
    mux_in[4*W +: W] = 32'hCAFEF00D;
    alu_src_sel = 3'd4;
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    step();
    step();
    check("full_rdy", 32'(in_ready), 32'd0);
    reset    = 1'b1;
    in_valid = 1'b0;
    step();
    check("rf_valid", 32'(out_valid), 32'd0);
    check("rf_rdy", 32'(in_ready), 32'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    step();
    check("rf_rel_rdy", 32'(in_ready), 32'd1);
    check("rf_rel_valid", 32'(out_valid), 32'd0);
    step();
    check("rf_no_stale", 32'(out_valid), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      for (int k = 0; k < int'(NIN); k++) mux_in[k*W +: W] = $urandom();
      alu_src_sel = SELW'($urandom_range(0, 7));
      ext_mode    = 2'($urandom_range(0, 3));
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      err_clr     = ($urandom_range(0, 7) == 0);
      reset       = ($urandom_range(0, 99) == 0);
      step();
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
